// File: rtl/start_stop_conditioner.sv
// Synchronise and debounce the raw start/stop push-buttons and turn each
// debounced press into a single-cycle pulse, with stop winning any collision.

module start_stop_conditioner_chan #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic rise_c
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Two-flop synchroniser; only sync2_q is used past this point.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_c  = level_d & ~level_q;

endmodule

module start_stop_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_start_raw,
  input  logic btn_stop_raw,
  output logic start,
  output logic stop,
  output logic start_level,
  output logic stop_level
);

  logic start_rise_c;
  logic stop_rise_c;
  logic start_q;
  logic start_d;
  logic stop_q;
  logic stop_d;

  start_stop_conditioner_chan #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_start_chan (
    .clk     (clk),
    .reset   (reset),
    .raw_i   (btn_start_raw),
    .level_o (start_level),
    .rise_c  (start_rise_c)
  );

  start_stop_conditioner_chan #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_stop_chan (
    .clk     (clk),
    .reset   (reset),
    .raw_i   (btn_stop_raw),
    .level_o (stop_level),
    .rise_c  (stop_rise_c)
  );

  // A colliding start press is dropped, not deferred.
  always_comb begin
    start_d = start_rise_c & ~stop_rise_c;
    stop_d  = stop_rise_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      start_q <= start_d;
      stop_q  <= stop_d;
    end
  end

  assign start = start_q;
  assign stop  = stop_q;

endmodule

// File: tb/tb_start_stop_conditioner.sv
// Directed bench for start_stop_conditioner: debounce latency, bounce rejection,
// start/stop collision, reset mid-press, single-cycle debounce and a counter model.

module tb_start_stop_conditioner;

  logic clk = 1'b0;
  logic reset;
  logic start_raw4, stop_raw4, start_raw1, stop_raw1;
  logic start4, stop4, start_lvl4, stop_lvl4;
  logic start1, stop1, start_lvl1, stop_lvl1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_start4, n_stop4, n_start1, n_stop1;

  logic       cnt_en;
  logic [3:0] cnt_val;

  always #5 clk = ~clk;

  start_stop_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) u_dut4 (
    .clk           (clk),
    .reset         (reset),
    .btn_start_raw (start_raw4),
    .btn_stop_raw  (stop_raw4),
    .start         (start4),
    .stop          (stop4),
    .start_level   (start_lvl4),
    .stop_level    (stop_lvl4)
  );

  start_stop_conditioner #(.DEBOUNCE_CYCLES(1), .CNT_W(4)) u_dut1 (
    .clk           (clk),
    .reset         (reset),
    .btn_start_raw (start_raw1),
    .btn_stop_raw  (stop_raw1),
    .start         (start1),
    .stop          (stop1),
    .start_level   (start_lvl1),
    .stop_level    (stop_lvl1)
  );

  // Downstream mod-14 enabled counter fed by the 4-cycle instance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_en  <= 1'b0;
      cnt_val <= 4'd0;
    end else begin
      if (start4)     cnt_en <= 1'b1;
      else if (stop4) cnt_en <= 1'b0;
      if (cnt_en) cnt_val <= (cnt_val == 4'd13) ? 4'd0 : cnt_val + 4'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      n_start4 += int'(start4);
      n_stop4  += int'(stop4);
      n_start1 += int'(start1);
      n_stop1  += int'(stop1);
    end
  endtask

  task automatic clear_counts();
    n_start4 = 0; n_stop4 = 0; n_start1 = 0; n_stop1 = 0;
  endtask

  initial begin
    reset = 1'b1;
    start_raw4 = 1'b0; stop_raw4 = 1'b0; start_raw1 = 1'b0; stop_raw1 = 1'b0;
    clear_counts();
    tick(2);
    check("rst_start", 32'(start4), 0);
    check("rst_stop", 32'(stop4), 0);
    check("rst_start_lvl", 32'(start_lvl4), 0);
    check("rst_stop_lvl", 32'(stop_lvl4), 0);
    reset = 1'b0;
    tick(2);
    check("post_rst_start", 32'(start4), 0);
    check("post_rst_lvl", 32'(start_lvl4), 0);

    // 1: clean held start press
    clear_counts();
    start_raw4 = 1'b1;
    tick(5);
    check("t1_early_pulse", 32'(start4), 0);
    check("t1_early_lvl", 32'(start_lvl4), 0);
    tick(1);
    check("t1_pulse", 32'(start4), 1);
    check("t1_lvl", 32'(start_lvl4), 1);
    check("t1_stop", 32'(stop4), 0);
    tick(1);
    check("t1_pulse_end", 32'(start4), 0);
    check("t1_lvl_hold", 32'(start_lvl4), 1);
    tick(13);
    check("t1_n_start", 32'(n_start4), 1);
    check("t1_n_stop", 32'(n_stop4), 0);

    // 2: bouncing stop press
    start_raw4 = 1'b0;
    tick(10);
    check("t2_start_rel_lvl", 32'(start_lvl4), 0);
    check("t2_start_rel_pulses", 32'(n_start4), 1);
    clear_counts();
    stop_raw4 = 1'b1; tick(1);
    stop_raw4 = 1'b0; tick(1);
    stop_raw4 = 1'b1; tick(1);
    stop_raw4 = 1'b0; tick(1);
    stop_raw4 = 1'b1;
    tick(5);
    check("t2_no_bounce_pulse", 32'(n_stop4), 0);
    check("t2_early_lvl", 32'(stop_lvl4), 0);
    tick(1);
    check("t2_pulse", 32'(stop4), 1);
    check("t2_lvl", 32'(stop_lvl4), 1);
    tick(10);
    check("t2_n_stop", 32'(n_stop4), 1);

    // 3: simultaneous press, stop wins
    stop_raw4 = 1'b0;
    tick(10);
    check("t3_stop_rel_lvl", 32'(stop_lvl4), 0);
    clear_counts();
    start_raw4 = 1'b1; stop_raw4 = 1'b1;
    tick(6);
    check("t3_stop_pulse", 32'(stop4), 1);
    check("t3_start_blocked", 32'(start4), 0);
    check("t3_start_lvl", 32'(start_lvl4), 1);
    check("t3_stop_lvl", 32'(stop_lvl4), 1);
    tick(14);
    check("t3_n_start", 32'(n_start4), 0);
    check("t3_n_stop", 32'(n_stop4), 1);
    start_raw4 = 1'b0; stop_raw4 = 1'b0;
    tick(10);
    clear_counts();
    start_raw4 = 1'b1;
    tick(6);
    check("t3_start_alone", 32'(start4), 1);
    tick(10);
    check("t3_n_start_alone", 32'(n_start4), 1);
    check("t3_n_stop_alone", 32'(n_stop4), 0);

    // 4: reset asserted mid-debounce with buttons held
    start_raw4 = 1'b0;
    tick(10);
    clear_counts();
    start_raw1 = 1'b1;
    start_raw4 = 1'b1;
    tick(4);
    check("t4_d1_lvl_before", 32'(start_lvl1), 1);
    check("t4_d4_lvl_before", 32'(start_lvl4), 0);
    reset = 1'b1;
    #1;
    check("t4_async_lvl1", 32'(start_lvl1), 0);
    check("t4_async_start4", 32'(start4), 0);
    tick(3);
    reset = 1'b0;
    clear_counts();
    tick(2);
    check("t4_d1_lvl_e2", 32'(start_lvl1), 0);
    tick(1);
    check("t4_d1_lvl_e3", 32'(start_lvl1), 1);
    check("t4_d1_pulse_e3", 32'(start1), 1);
    tick(2);
    check("t4_d4_early", 32'(start4), 0);
    check("t4_d4_early_lvl", 32'(start_lvl4), 0);
    tick(1);
    check("t4_d4_pulse", 32'(start4), 1);
    check("t4_d4_lvl", 32'(start_lvl4), 1);
    tick(10);
    check("t4_n_start4", 32'(n_start4), 1);
    check("t4_n_start1", 32'(n_start1), 1);

    // 5: single-cycle glitch with DEBOUNCE_CYCLES=1
    start_raw1 = 1'b0; start_raw4 = 1'b0;
    tick(10);
    check("t5_idle_lvl", 32'(start_lvl1), 0);
    clear_counts();
    start_raw1 = 1'b1; tick(1);
    start_raw1 = 1'b0; tick(1);
    check("t5_e2_lvl", 32'(start_lvl1), 0);
    check("t5_e2_pulse", 32'(start1), 0);
    tick(1);
    check("t5_e3_lvl", 32'(start_lvl1), 1);
    check("t5_e3_pulse", 32'(start1), 1);
    tick(1);
    check("t5_e4_lvl", 32'(start_lvl1), 0);
    check("t5_e4_pulse", 32'(start1), 0);
    tick(5);
    check("t5_n_start1", 32'(n_start1), 1);
    check("t5_n_stop1", 32'(n_stop1), 0);

    // 6: start then stop 10 cycles later into the downstream counter
    reset = 1'b1; tick(1);
    reset = 1'b0; tick(1);
    clear_counts();
    start_raw4 = 1'b1;
    tick(6);
    check("t6_start_pulse", 32'(start4), 1);
    check("t6_en_not_yet", 32'(cnt_en), 0);
    tick(1);
    check("t6_en", 32'(cnt_en), 1);
    check("t6_cnt0", 32'(cnt_val), 0);
    tick(1);
    check("t6_cnt1", 32'(cnt_val), 1);
    tick(2);
    stop_raw4 = 1'b1;
    tick(6);
    check("t6_stop_pulse", 32'(stop4), 1);
    check("t6_cnt9", 32'(cnt_val), 9);
    tick(1);
    check("t6_cnt10", 32'(cnt_val), 10);
    check("t6_en_off", 32'(cnt_en), 0);
    tick(8);
    check("t6_cnt_frozen", 32'(cnt_val), 10);
    check("t6_n_start", 32'(n_start4), 1);
    check("t6_n_stop", 32'(n_stop4), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
